// File: rtl/age_ordered_rs_pkg.sv
// Shared sizing for the reservation stations: ROB index width, op-type width, default depth/ports.
// Latency: n/a (constants only).
// Backpressure: n/a.
package age_ordered_rs_pkg;

    // ROB index width and functional-unit op-type width used across the core.
    localparam int ROB_SIZE_BIT = 5;
    localparam int RS_TYPE_BIT  = 4;

    // Default station geometry; individual units override through parameters.
    localparam int RS_DEPTH     = 8;
    localparam int RS_WB_PORTS  = 2;

endpackage

// File: rtl/age_ordered_rs_if.sv
// Issue / writeback / execute bundle between rename, the writeback buses, the station and its unit.
// Latency: n/a (wires only).
// Backpressure: iss_valid/iss_ready toward rename, ex_valid/ex_ready toward the execution unit.
// Ports: iss_* issue request, wb_* writeback broadcast, ex_* dispatch to unit, count occupancy.
interface age_ordered_rs_if import age_ordered_rs_pkg::*; #(
    parameter int DEPTH    = RS_DEPTH,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = ROB_SIZE_BIT,
    parameter int TYPE_W   = RS_TYPE_BIT,
    parameter int WB_PORTS = RS_WB_PORTS
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                         iss_valid;
    logic                         iss_ready;
    logic [TYPE_W-1:0]            iss_type;
    logic [ROB_W-1:0]             iss_rob_idx;
    logic [DATA_W-1:0]            iss_r1;
    logic [DATA_W-1:0]            iss_r2;
    logic [ROB_W-1:0]             iss_dep1;
    logic [ROB_W-1:0]             iss_dep2;
    logic                         iss_has_dep1;
    logic                         iss_has_dep2;

    logic [WB_PORTS-1:0]          wb_valid;
    logic [WB_PORTS*ROB_W-1:0]    wb_idx;
    logic [WB_PORTS*DATA_W-1:0]   wb_value;

    logic                         ex_valid;
    logic                         ex_ready;
    logic [TYPE_W-1:0]            ex_op;
    logic [ROB_W-1:0]             ex_rob_idx;
    logic [DATA_W-1:0]            ex_r1;
    logic [DATA_W-1:0]            ex_r2;

    logic [CNT_W-1:0]             count;

    // Producer side: rename stage, writeback buses and execution unit.
    modport master (
        output iss_valid, iss_type, iss_rob_idx, iss_r1, iss_r2,
               iss_dep1, iss_dep2, iss_has_dep1, iss_has_dep2,
        input  iss_ready,
        output wb_valid, wb_idx, wb_value,
        input  ex_valid, ex_op, ex_rob_idx, ex_r1, ex_r2,
        output ex_ready,
        input  count
    );

    // The reservation station itself.
    modport slave (
        input  iss_valid, iss_type, iss_rob_idx, iss_r1, iss_r2,
               iss_dep1, iss_dep2, iss_has_dep1, iss_has_dep2,
        output iss_ready,
        input  wb_valid, wb_idx, wb_value,
        output ex_valid, ex_op, ex_rob_idx, ex_r1, ex_r2,
        input  ex_ready,
        output count
    );
endinterface

// File: rtl/age_ordered_rs_age_select.sv
// Age matrix plus oldest-ready picker and lowest-free-slot encoder for a DEPTH-entry station.
// Latency: picks are combinational from registered state; matrix updates on the clock edge.
// Backpressure: none of its own; the parent gates ins_fire/rm_fire with its handshakes.
// Ports: clk_in/rst_in, rdy_in freeze, flush clear, busy/ready vectors, insert/remove strobes,
//        free_idx (lowest free slot), sel_idx/sel_vld (oldest ready entry).
module age_ordered_rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush,
    input  logic [DEPTH-1:0]           busy,
    input  logic [DEPTH-1:0]           ready,
    input  logic                       ins_fire,
    input  logic                       rm_fire,
    output logic [$clog2(DEPTH)-1:0]   free_idx,
    output logic [$clog2(DEPTH)-1:0]   sel_idx,
    output logic                       sel_vld
);
    localparam int IDX_W = $clog2(DEPTH);

    // older_q[i][j] set means entry i was inserted before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [DEPTH-1:0] oldest;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    // An entry is oldest-ready when no other ready entry is older than it.
    always_comb begin
        oldest  = '0;
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) oldest[i] = 1'b0;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (oldest[i]) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end

    // Removal clears row and column; a new entry is younger than every entry still busy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                older_d[i][j] = older_q[i][j];
                if (rm_fire && ((IDX_W'(i) == sel_idx) || (IDX_W'(j) == sel_idx)))
                    older_d[i][j] = 1'b0;
                if (ins_fire && (IDX_W'(j) == free_idx))
                    older_d[i][j] = busy[i] && !(rm_fire && (IDX_W'(i) == sel_idx));
                if (ins_fire && (IDX_W'(i) == free_idx))
                    older_d[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
        end
    end
endmodule

// File: rtl/age_ordered_rs.sv
// Reservation station: buffers issued ops, captures operands off writeback, dispatches oldest ready.
// Latency: issue-to-dispatch and wakeup-to-dispatch 1 cycle; readiness comes only from registered state.
// Backpressure: iss_ready from registered count (a same-cycle dispatch does not free a slot); ex_ready low holds entries.
// Ports: clk_in, rst_in (async high), rdy_in (freeze), flush (sync clear), rs (slave side of the bundle).
module age_ordered_rs import age_ordered_rs_pkg::*; #(
    parameter int DEPTH    = RS_DEPTH,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = ROB_SIZE_BIT,
    parameter int TYPE_W   = RS_TYPE_BIT,
    parameter int WB_PORTS = RS_WB_PORTS
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush,
    age_ordered_rs_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]   busy_q, has1_q, has2_q;
    logic [TYPE_W-1:0]  op_q   [DEPTH];
    logic [ROB_W-1:0]   rob_q  [DEPTH];
    logic [ROB_W-1:0]   dep1_q [DEPTH];
    logic [ROB_W-1:0]   dep2_q [DEPTH];
    logic [DATA_W-1:0]  r1_q   [DEPTH];
    logic [DATA_W-1:0]  r2_q   [DEPTH];
    logic [CNT_W-1:0]   count_q;

    logic [DEPTH-1:0]   ready_vec;
    logic [IDX_W-1:0]   free_idx, sel_idx;
    logic               sel_vld;
    logic               iss_fire, dsp_fire;

    logic [DEPTH-1:0]   wk1_hit, wk2_hit;
    logic [DATA_W-1:0]  wk1_val [DEPTH];
    logic [DATA_W-1:0]  wk2_val [DEPTH];
    logic               byp1_hit, byp2_hit;
    logic [DATA_W-1:0]  byp1_val, byp2_val;

    // Returns {hit, value}; scanning high to low lets the lowest matching port win.
    function automatic logic [DATA_W:0] wb_lookup(
        input logic [ROB_W-1:0]           dep,
        input logic [WB_PORTS-1:0]        vld,
        input logic [WB_PORTS*ROB_W-1:0]  idx,
        input logic [WB_PORTS*DATA_W-1:0] val
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (vld[p] && (idx[p*ROB_W +: ROB_W] == dep))
                res = {1'b1, val[p*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    assign ready_vec = busy_q & ~has1_q & ~has2_q;
    assign rs.iss_ready = (count_q < CNT_W'(DEPTH));
    assign rs.ex_valid  = rdy_in && sel_vld;
    assign rs.count     = count_q;
    assign iss_fire     = rs.iss_valid && rs.iss_ready && rdy_in;
    assign dsp_fire     = rs.ex_valid && rs.ex_ready;

    age_ordered_rs_age_select #(.DEPTH(DEPTH)) u_age_select (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .busy     (busy_q),
        .ready    (ready_vec),
        .ins_fire (iss_fire),
        .rm_fire  (dsp_fire),
        .free_idx (free_idx),
        .sel_idx  (sel_idx),
        .sel_vld  (sel_vld)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {wk1_hit[i], wk1_val[i]} = wb_lookup(dep1_q[i], rs.wb_valid, rs.wb_idx, rs.wb_value);
            {wk2_hit[i], wk2_val[i]} = wb_lookup(dep2_q[i], rs.wb_valid, rs.wb_idx, rs.wb_value);
        end
        {byp1_hit, byp1_val} = wb_lookup(rs.iss_dep1, rs.wb_valid, rs.wb_idx, rs.wb_value);
        {byp2_hit, byp2_val} = wb_lookup(rs.iss_dep2, rs.wb_valid, rs.wb_idx, rs.wb_value);
    end

    always_comb begin
        rs.ex_op      = '0;
        rs.ex_rob_idx = '0;
        rs.ex_r1      = '0;
        rs.ex_r2      = '0;
        if (rs.ex_valid) begin
            rs.ex_op      = op_q[sel_idx];
            rs.ex_rob_idx = rob_q[sel_idx];
            rs.ex_r1      = r1_q[sel_idx];
            rs.ex_r2      = r2_q[sel_idx];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            has1_q  <= '0;
            has2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                rob_q[i]  <= '0;
                dep1_q[i] <= '0;
                dep2_q[i] <= '0;
                r1_q[i]   <= '0;
                r2_q[i]   <= '0;
            end
        end else if (flush) begin
            busy_q  <= '0;
            has1_q  <= '0;
            has2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                rob_q[i]  <= '0;
                dep1_q[i] <= '0;
                dep2_q[i] <= '0;
                r1_q[i]   <= '0;
                r2_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            // A dispatching entry is never pending, so wakeup cannot touch it.
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && has1_q[i] && wk1_hit[i]) begin
                    r1_q[i]   <= wk1_val[i];
                    has1_q[i] <= 1'b0;
                end
                if (busy_q[i] && has2_q[i] && wk2_hit[i]) begin
                    r2_q[i]   <= wk2_val[i];
                    has2_q[i] <= 1'b0;
                end
            end
            if (dsp_fire) busy_q[sel_idx] <= 1'b0;
            // free_idx is an idle slot, so this never collides with the wakeup writes above.
            if (iss_fire) begin
                busy_q[free_idx] <= 1'b1;
                op_q[free_idx]   <= rs.iss_type;
                rob_q[free_idx]  <= rs.iss_rob_idx;
                dep1_q[free_idx] <= rs.iss_dep1;
                dep2_q[free_idx] <= rs.iss_dep2;
                has1_q[free_idx] <= rs.iss_has_dep1 && !byp1_hit;
                has2_q[free_idx] <= rs.iss_has_dep2 && !byp2_hit;
                r1_q[free_idx]   <= (rs.iss_has_dep1 && byp1_hit) ? byp1_val : rs.iss_r1;
                r2_q[free_idx]   <= (rs.iss_has_dep2 && byp2_hit) ? byp2_val : rs.iss_r2;
            end
            case ({iss_fire, dsp_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_age_ordered_rs.sv
// Self-checking bench for age_ordered_rs: directed issue/wakeup/dispatch sequences with a dispatch scoreboard.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: ex_ready driven per scenario; every wait is bounded.
module tb_age_ordered_rs;
    import age_ordered_rs_pkg::*;

    localparam int DEPTH    = 8;
    localparam int DATA_W   = 32;
    localparam int ROB_W    = ROB_SIZE_BIT;
    localparam int TYPE_W   = RS_TYPE_BIT;
    localparam int WB_PORTS = 2;

    typedef struct packed {
        logic [TYPE_W-1:0] op;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    age_ordered_rs_if #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .WB_PORTS(WB_PORTS)
    ) bus ();

    age_ordered_rs #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .WB_PORTS(WB_PORTS)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .rs     (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [TYPE_W-1:0] op, input logic [ROB_W-1:0] rob,
                         input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                         input logic h1, input logic [ROB_W-1:0] d1,
                         input logic h2, input logic [ROB_W-1:0] d2);
        bus.iss_valid    = 1'b1;
        bus.iss_type     = op;
        bus.iss_rob_idx  = rob;
        bus.iss_r1       = r1;
        bus.iss_r2       = r2;
        bus.iss_has_dep1 = h1;
        bus.iss_dep1     = d1;
        bus.iss_has_dep2 = h2;
        bus.iss_dep2     = d2;
        step();
        bus.iss_valid    = 1'b0;
        bus.iss_has_dep1 = 1'b0;
        bus.iss_has_dep2 = 1'b0;
    endtask

    // Every accepted dispatch must match the oldest outstanding expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && bus.ex_valid && bus.ex_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_dispatch", 64'(bus.ex_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("dsp_op",  64'(bus.ex_op),      64'(e.op));
                    check_val("dsp_rob", 64'(bus.ex_rob_idx), 64'(e.rob));
                    check_val("dsp_r1",  64'(bus.ex_r1),      64'(e.r1));
                    check_val("dsp_r2",  64'(bus.ex_r2),      64'(e.r2));
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.ex_ready = 1'b1;
        while (sb_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check_val(tag, 64'(sb_q.size()), 64'd0);
        check_val({tag, "_count"}, 64'(bus.count), 64'd0);
        bus.ex_ready = 1'b0;
    endtask

    initial begin
        bus.iss_valid = 1'b0; bus.iss_type = '0; bus.iss_rob_idx = '0;
        bus.iss_r1 = '0; bus.iss_r2 = '0; bus.iss_dep1 = '0; bus.iss_dep2 = '0;
        bus.iss_has_dep1 = 1'b0; bus.iss_has_dep2 = 1'b0;
        bus.wb_valid = '0; bus.wb_idx = '0; bus.wb_value = '0;
        bus.ex_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_val("rst_count",     64'(bus.count),     64'd0);
        check_val("rst_iss_ready", 64'(bus.iss_ready), 64'd1);
        check_val("rst_ex_valid",  64'(bus.ex_valid),  64'd0);
        check_val("rst_ex_r1",     64'(bus.ex_r1),     64'd0);
        rst_in = 1'b0;
        step();

        // Age order beats slot and ROB order: Q, A, free slot 0, then B lands in slot 0
        issue(4'h1, 5'd9, 32'h90, 32'h91, 1'b0, 5'd0, 1'b0, 5'd0);
        sb_q.push_back('{4'h1, 5'd9, 32'h90, 32'h91});
        issue(4'h2, 5'd3, 32'hA1, 32'hA2, 1'b0, 5'd0, 1'b0, 5'd0);
        sb_q.push_back('{4'h2, 5'd3, 32'hA1, 32'hA2});
        bus.ex_ready = 1'b1;
        @(negedge clk_in);
        check_val("age_first_sel", 64'(bus.ex_rob_idx), 64'd9);
        step();
        bus.ex_ready = 1'b0;
        issue(4'h3, 5'd1, 32'hB1, 32'hB2, 1'b0, 5'd0, 1'b0, 5'd0);
        sb_q.push_back('{4'h3, 5'd1, 32'hB1, 32'hB2});
        repeat (3) begin
            @(negedge clk_in);
            check_val("age_hold_sel", 64'(bus.ex_rob_idx), 64'd3);
            check_val("age_hold_cnt", 64'(bus.count),      64'd2);
            step();
        end
        drain("age_drain");

        // Issue-time bypass from wb port 1; no dispatch in the issue cycle
        bus.wb_valid = 2'b11;
        bus.wb_idx   = {5'd5, 5'd9};
        bus.wb_value = {32'hDEADBEEF, 32'h99};
        bus.iss_valid = 1'b1; bus.iss_type = 4'h2; bus.iss_rob_idx = 5'd7;
        bus.iss_r1 = 32'h0; bus.iss_r2 = 32'h33;
        bus.iss_has_dep1 = 1'b1; bus.iss_dep1 = 5'd5; bus.iss_has_dep2 = 1'b0;
        sb_q.push_back('{4'h2, 5'd7, 32'hDEADBEEF, 32'h33});
        bus.ex_ready = 1'b1;
        @(negedge clk_in);
        check_val("empty_no_same_cycle", 64'(bus.ex_valid), 64'd0);
        step();
        bus.iss_valid = 1'b0; bus.iss_has_dep1 = 1'b0; bus.wb_valid = '0;
        @(negedge clk_in);
        check_val("bypass_lat1", 64'(bus.ex_valid), 64'd1);
        step();
        bus.ex_ready = 1'b0;

        // Two pending operands woken by two ports in the same cycle
        issue(4'h3, 5'd4, 32'h0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd6);
        sb_q.push_back('{4'h3, 5'd4, 32'h11, 32'h22});
        bus.ex_ready = 1'b1;
        @(negedge clk_in);
        check_val("pending_no_valid", 64'(bus.ex_valid), 64'd0);
        step();
        bus.wb_valid = 2'b11;
        bus.wb_idx   = {5'd6, 5'd2};
        bus.wb_value = {32'h22, 32'h11};
        @(negedge clk_in);
        check_val("wake_same_cycle", 64'(bus.ex_valid), 64'd0);
        step();
        bus.wb_valid = '0;
        @(negedge clk_in);
        check_val("wake_lat1", 64'(bus.ex_valid), 64'd1);
        step();
        bus.ex_ready = 1'b0;

        // Both ports match one dependency: port 0 wins
        issue(4'h5, 5'd12, 32'h0, 32'h55, 1'b1, 5'd8, 1'b0, 5'd0);
        sb_q.push_back('{4'h5, 5'd12, 32'hAA, 32'h55});
        bus.wb_valid = 2'b11;
        bus.wb_idx   = {5'd8, 5'd8};
        bus.wb_value = {32'hBB, 32'hAA};
        step();
        bus.wb_valid = '0;
        drain("prio_drain");

        // rdy_in low freezes state and masks ex_valid, iss_ready unaffected
        issue(4'h6, 5'd13, 32'h61, 32'h62, 1'b0, 5'd0, 1'b0, 5'd0);
        sb_q.push_back('{4'h6, 5'd13, 32'h61, 32'h62});
        rdy_in = 1'b0;
        bus.ex_ready = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_type = 4'h7; bus.iss_rob_idx = 5'd14;
        @(negedge clk_in);
        check_val("frozen_ex_valid",  64'(bus.ex_valid),  64'd0);
        check_val("frozen_iss_ready", 64'(bus.iss_ready), 64'd1);
        step();
        bus.iss_valid = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk_in);
        check_val("frozen_count", 64'(bus.count), 64'd1);
        step();
        drain("frozen_drain");

        // Fill, then dispatch with issue held: no insert while full, insert next cycle
        for (int i = 0; i < DEPTH; i++) begin
            issue(4'(i), 5'(16 + i), 32'(32'h100 + i), 32'(32'h200 + i), 1'b0, 5'd0, 1'b0, 5'd0);
            sb_q.push_back('{4'(i), 5'(16 + i), 32'(32'h100 + i), 32'(32'h200 + i)});
        end
        @(negedge clk_in);
        check_val("full_count",     64'(bus.count),     64'd8);
        check_val("full_iss_ready", 64'(bus.iss_ready), 64'd0);
        step();
        bus.ex_ready = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_type = 4'hF; bus.iss_rob_idx = 5'd30;
        bus.iss_r1 = 32'h300; bus.iss_r2 = 32'h301;
        sb_q.push_back('{4'hF, 5'd30, 32'h300, 32'h301});
        @(negedge clk_in);
        check_val("full_dsp_iss_ready", 64'(bus.iss_ready), 64'd0);
        step();
        bus.ex_ready = 1'b0;
        @(negedge clk_in);
        check_val("full_after_dsp", 64'(bus.count),     64'd7);
        check_val("full_slot_free", 64'(bus.iss_ready), 64'd1);
        step();
        bus.iss_valid = 1'b0;
        @(negedge clk_in);
        check_val("full_refill", 64'(bus.count), 64'd8);
        step();
        drain("full_drain");

        // Flush during concurrent issue and wakeup
        issue(4'h8, 5'd10, 32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0);
        issue(4'h9, 5'd11, 32'h3, 32'h4, 1'b1, 5'd15, 1'b0, 5'd0);
        flush = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_type = 4'hA; bus.iss_rob_idx = 5'd20;
        bus.wb_valid = 2'b01; bus.wb_idx = {5'd0, 5'd15}; bus.wb_value = {32'h0, 32'h77};
        step();
        flush = 1'b0;
        bus.iss_valid = 1'b0;
        bus.wb_valid = '0;
        @(negedge clk_in);
        check_val("flush_count",     64'(bus.count),     64'd0);
        check_val("flush_ex_valid",  64'(bus.ex_valid),  64'd0);
        check_val("flush_iss_ready", 64'(bus.iss_ready), 64'd1);
        step();
        bus.ex_ready = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check_val("flush_no_dispatch", 64'(bus.ex_valid), 64'd0);
            step();
        end
        bus.ex_ready = 1'b0;

        // Asynchronous reset with five entries busy takes effect before the next edge
        for (int i = 0; i < 5; i++) begin
            issue(4'(i), 5'(i), 32'(i), 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
        end
        @(negedge clk_in);
        check_val("pre_rst_count", 64'(bus.count), 64'd5);
        #1 rst_in = 1'b1;
        #1;
        check_val("arst_count",     64'(bus.count),     64'd0);
        check_val("arst_ex_valid",  64'(bus.ex_valid),  64'd0);
        check_val("arst_iss_ready", 64'(bus.iss_ready), 64'd1);
        step();
        rst_in = 1'b0;
        @(negedge clk_in);
        check_val("post_rst_count", 64'(bus.count), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
